// File: rtl/score_bcd_converter.sv
// score_bcd_converter
// Converts the game controller's binary score and attempts counters into
// 3-digit BCD with leading-zero blanking masks. One shared shift-and-add-3
// engine handles score first, then attempts, once per frameStart pulse.
// The digits and blank masks only change as a pair, so the digit drawers
// never see a mask that belongs to a different value.

module score_bcd_converter #(
  parameter int DATA_W       = 8,
  parameter int SHIFT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              frameStart,
  input  logic [DATA_W-1:0] score,
  input  logic [DATA_W-1:0] attempts,
  output logic [11:0]       scoreDigits,
  output logic [11:0]       attemptsDigits,
  output logic [2:0]        scoreBlank,
  output logic [2:0]        attemptsBlank,
  output logic              busy,
  output logic              updated
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CONV_SCORE = 2'd1;
  localparam logic [1:0] CONV_ATT   = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'(SHIFT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [11:0]       acc_q, acc_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] att_snap_q, att_snap_d;
  logic [11:0]       score_dig_q, score_dig_d;
  logic [11:0]       att_dig_q, att_dig_d;
  logic [2:0]        score_blank_q, score_blank_d;
  logic [2:0]        att_blank_q, att_blank_d;
  logic              busy_q, busy_d;
  logic              updated_q, updated_d;

  // Correction and shift for the current iteration. Kept outside the FSM so
  // the final iteration's value is available to write straight to the outputs.
  logic [11:0] adj;
  logic [11:0] acc_shifted;

  // Add 3 to every BCD nibble of 5 or more, so that the next left shift
  // carries correctly into the neighbouring decimal digit.
  function automatic logic [11:0] add3(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Hundreds blanks when zero; tens blanks only when hundreds is blank too.
  // The ones digit always shows, so zero is drawn as a single "0".
  function automatic logic [2:0] blank_mask(input logic [11:0] d);
    return {d[11:8] == 4'd0, d[11:4] == 8'd0, 1'b0};
  endfunction

  // One double-dabble iteration: correct the accumulator, then shift the
  // top bit of the snapshot into it.
  always_comb begin
    adj         = add3(acc_q);
    acc_shifted = 12'({adj, sh_q[DATA_W-1]});
  end

  // Next-state logic for the conversion sequencer and output registers.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    sh_d          = sh_q;
    att_snap_d    = att_snap_q;
    score_dig_d   = score_dig_q;
    att_dig_d     = att_dig_q;
    score_blank_d = score_blank_q;
    att_blank_d   = att_blank_q;
    busy_d        = busy_q;
    updated_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Both inputs are captured on the same edge, so later changes from
        // the game controller cannot leak into this frame's digits.
        if (frameStart) begin
          sh_d       = score;
          att_snap_d = attempts;
          acc_d      = 12'd0;
          cnt_d      = 4'd0;
          busy_d     = 1'b1;
          state_d    = CONV_SCORE;
        end
      end

      CONV_SCORE, CONV_ATT: begin
        acc_d = acc_shifted;
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          cnt_d = 4'd0;
          acc_d = 12'd0;
          if (state_q == CONV_SCORE) begin
            score_dig_d   = acc_shifted;
            score_blank_d = blank_mask(acc_shifted);
            sh_d          = att_snap_q;
            state_d       = CONV_ATT;
          end else begin
            att_dig_d   = acc_shifted;
            att_blank_d = blank_mask(acc_shifted);
            busy_d      = 1'b0;
            updated_d   = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial conversion.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      acc_q         <= 12'd0;
      sh_q          <= '0;
      att_snap_q    <= '0;
      score_dig_q   <= 12'd0;
      att_dig_q     <= 12'd0;
      score_blank_q <= 3'b110;
      att_blank_q   <= 3'b110;
      busy_q        <= 1'b0;
      updated_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      sh_q          <= sh_d;
      att_snap_q    <= att_snap_d;
      score_dig_q   <= score_dig_d;
      att_dig_q     <= att_dig_d;
      score_blank_q <= score_blank_d;
      att_blank_q   <= att_blank_d;
      busy_q        <= busy_d;
      updated_q     <= updated_d;
    end
  end

  assign scoreDigits    = score_dig_q;
  assign attemptsDigits = att_dig_q;
  assign scoreBlank     = score_blank_q;
  assign attemptsBlank  = att_blank_q;
  assign busy           = busy_q;
  assign updated        = updated_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Testbench for score_bcd_converter: directed boundary cases plus an
// exhaustive and a random sweep, checked by a scoreboard whose monitor pops
// an expected result each time the DUT pulses updated.

module tb_score_bcd_converter;

  logic        clk;
  logic        resetN;
  logic        frameStart;
  logic [7:0]  score;
  logic [7:0]  attempts;
  logic [11:0] scoreDigits;
  logic [11:0] attemptsDigits;
  logic [2:0]  scoreBlank;
  logic [2:0]  attemptsBlank;
  logic        busy;
  logic        updated;

  int n_tests = 0;
  int n_fail  = 0;
  int n_upd   = 0;

  // Expected {scoreDigits, scoreBlank, attemptsDigits, attemptsBlank}
  logic [29:0] exp_q[$];

  // What the DUT should currently be presenting ({digits, blank})
  logic [14:0] last_s;
  logic [14:0] last_a;

  score_bcd_converter #(.DATA_W(8), .SHIFT_CYCLES(8)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .frameStart     (frameStart),
    .score          (score),
    .attempts       (attempts),
    .scoreDigits    (scoreDigits),
    .attemptsDigits (attemptsDigits),
    .scoreBlank     (scoreBlank),
    .attemptsBlank  (attemptsBlank),
    .busy           (busy),
    .updated        (updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, blanking from the digit values.
  function automatic logic [14:0] model(input int v);
    int h, t, o;
    logic [2:0] bl;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    bl = {h == 0, (h == 0) && (t == 0), 1'b0};
    return {4'(h), 4'(t), 4'(o), bl};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every updated pulse consumes one expected entry.
  always @(negedge clk) begin
    if (updated) begin
      logic [29:0] e;
      n_upd++;
      check("busy_low_during_updated", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_update: score %03h attempts %03h with nothing expected",
                 scoreDigits, attemptsDigits);
      end else begin
        e = exp_q.pop_front();
        check("score_digits",    {20'd0, scoreDigits},    {20'd0, e[29:18]});
        check("score_blank",     {29'd0, scoreBlank},     {29'd0, e[17:15]});
        check("attempts_digits", {20'd0, attemptsDigits}, {20'd0, e[14:3]});
        check("attempts_blank",  {29'd0, attemptsBlank},  {29'd0, e[2:0]});
        $display("[TB] update: score %03h blank %03b, attempts %03h blank %03b",
                 scoreDigits, scoreBlank, attemptsDigits, attemptsBlank);
      end
    end
  end

  // Run one conversion, called at a negedge while the DUT is idle.
  // mode 0: plain; mode 1: change score at N+3 and pulse frameStart at N+5;
  // mode 2: pulse frameStart so it is sampled on edge N+16.
  task automatic do_conv(input logic [7:0] s, input logic [7:0] a, input int mode);
    logic [14:0] ms, ma;
    int busy_cnt;
    int upd_at;
    bit got;
    ms = model(int'(s));
    ma = model(int'(a));
    score      = s;
    attempts   = a;
    frameStart = 1'b1;
    exp_q.push_back({ms, ma});
    busy_cnt = 0;
    upd_at   = -1;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);  // just after edge N+i
      frameStart = 1'b0;
      if (busy) busy_cnt++;
      if (i == 7) begin
        check("score_not_yet_written", {17'd0, scoreDigits, scoreBlank}, {17'd0, last_s});
      end
      if (i == 8) begin
        check("score_written_at_n8", {17'd0, scoreDigits, scoreBlank}, {17'd0, ms});
        check("attempts_old_at_n8", {17'd0, attemptsDigits, attemptsBlank}, {17'd0, last_a});
      end
      if (mode == 1 && i == 3) score = 8'd99;
      if (mode == 1 && i == 4) frameStart = 1'b1;
      if (mode == 2 && i == 15) frameStart = 1'b1;
      if (updated) begin
        got    = 1'b1;
        upd_at = i;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL update_timeout: no updated pulse within 40 cycles (score %0d attempts %0d)", s, a);
    end else begin
      check("update_latency", upd_at, 32'd16);
      check("busy_cycles", busy_cnt, 32'd16);
    end
    @(negedge clk);
    frameStart = 1'b0;
    check("updated_single_cycle", {31'd0, updated}, 32'd0);
    check("idle_after_conv", {31'd0, busy}, 32'd0);
    last_s = ms;
    last_a = ma;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_score_digits"},    {20'd0, scoreDigits},    32'd0);
    check({tag, "_attempts_digits"}, {20'd0, attemptsDigits}, 32'd0);
    check({tag, "_score_blank"},     {29'd0, scoreBlank},     32'h6);
    check({tag, "_attempts_blank"},  {29'd0, attemptsBlank},  32'h6);
    check({tag, "_busy"},            {31'd0, busy},           32'd0);
    check({tag, "_updated"},         {31'd0, updated},        32'd0);
  endtask

  initial begin
    int upd_before;
    resetN     = 1'b0;
    frameStart = 1'b0;
    score      = 8'd0;
    attempts   = 8'd0;
    last_s     = {12'h000, 3'b110};
    last_a     = {12'h000, 3'b110};
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_values("reset");

    do_conv(8'd255, 8'd16, 0);
    do_conv(8'd0, 8'd5, 0);

    // Mid-conversion input change and frameStart while busy are ignored.
    upd_before = n_upd;
    do_conv(8'd10, 8'd3, 1);
    repeat (30) @(negedge clk);
    check("single_update_when_busy_pulse", n_upd - upd_before, 32'd1);
    check("no_restart_after_busy_pulse", {31'd0, busy}, 32'd0);
    do_conv(8'd99, 8'd3, 0);

    // frameStart on the return-to-IDLE edge is dropped.
    do_conv(8'd123, 8'd200, 2);
    repeat (5) @(negedge clk);
    check("no_restart_at_n16", {31'd0, busy}, 32'd0);

    // Exhaustive sweep over both inputs.
    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), 8'(v) ^ 8'hA5, 0);
    end

    // Random values.
    for (int k = 0; k < 40; k++) begin
      do_conv(8'($urandom_range(255)), 8'($urandom_range(255)), 0);
    end

    // Reset in the middle of a conversion discards it.
    score      = 8'd200;
    attempts   = 8'd77;
    frameStart = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      frameStart = 1'b0;
    end
    #2 resetN = 1'b0;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
    upd_before = n_upd;
    repeat (40) @(negedge clk);
    check_reset_values("after_reset");
    check("no_update_after_reset", n_upd - upd_before, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
